// File: rtl/targ_fb_sched_if.sv
// Feedback record type and the source/predictor bundle for the target-predictor
// feedback scheduler.
package core;
  typedef struct packed {
    logic        valid;
    logic [31:0] base_pc;
    logic [31:0] target;
    logic        taken;
  } targ_pred_fb_t;
endpackage

interface targ_fb_sched_if #(parameter int num_src = 4);
  core::targ_pred_fb_t [num_src-1:0] src_fb;
  logic [num_src-1:0]                src_ready;
  core::targ_pred_fb_t               pred_fb;
  logic                              pred_en;
  logic                              pred_rst;

  modport master (output src_fb, input src_ready, pred_fb, pred_en, pred_rst);
  modport slave  (input src_fb, output src_ready, pred_fb, pred_en, pred_rst);
endinterface

// File: rtl/targ_fb_sched.sv
// Round-robin feedback arbiter, FIFO and predictor clear sequencer. Flush or reset
// empties the FIFO and holds pred_rst for rst_hold cycles before training resumes.
module targ_fb_sched #(
  parameter int num_src    = 4,
  parameter int fifo_depth = 8,
  parameter int rst_hold   = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              stall,
  targ_fb_sched_if.slave                    bus,
  output logic [$clog2(fifo_depth+1)-1:0]   occupancy,
  output logic                              busy
);
  localparam int SW = $clog2(num_src);
  localparam int AW = $clog2(fifo_depth);
  localparam int OW = $clog2(fifo_depth+1);
  localparam int HW = $clog2(rst_hold+1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [SW-1:0]       rr_q, rr_d;
  logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [OW-1:0]       occ_q, occ_d;
  core::targ_pred_fb_t mem_q [fifo_depth];

  logic          run, full, empty, push, pop, found;
  logic [SW-1:0] sel;
  logic [SW:0]   cand;

  assign run   = (state_q == RUN);
  assign full  = (occ_q == OW'(fifo_depth));
  assign empty = (occ_q == '0);
  assign push  = run && found && !full && !flush;
  assign pop   = run && !empty && !flush && !stall;

  // First valid source at or after rr_q, wrapping modulo num_src.
  always_comb begin
    sel   = rr_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < num_src; k++) begin
      cand = {1'b0, rr_q} + (SW+1)'(k);
      if (cand >= (SW+1)'(num_src)) cand = cand - (SW+1)'(num_src);
      if (!found && bus.src_fb[cand[SW-1:0]].valid) begin
        found = 1'b1;
        sel   = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    bus.src_ready = '0;
    if (push) bus.src_ready[sel] = 1'b1;
  end

  always_comb begin
    bus.pred_fb = '0;
    if (run && !empty && !flush) begin
      bus.pred_fb       = mem_q[rp_q];
      bus.pred_fb.valid = 1'b1;
    end
  end

  assign bus.pred_en  = run && !stall;
  assign bus.pred_rst = !run;
  assign occupancy    = occ_q;
  assign busy         = !run || (occ_q != '0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rr_d    = rr_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    occ_d   = occ_q;
    case (state_q)
      CLEAR: begin
        wp_d  = '0;
        rp_d  = '0;
        occ_d = '0;
        // A flush during the clear window restarts the full hold period.
        if (flush)              hold_d  = HW'(rst_hold-1);
        else if (hold_q == '0)  state_d = RUN;
        else                    hold_d  = hold_q - HW'(1);
      end
      RUN: begin
        if (flush) begin
          state_d = CLEAR;
          hold_d  = HW'(rst_hold-1);
          wp_d    = '0;
          rp_d    = '0;
          occ_d   = '0;
        end else begin
          if (push) begin
            wp_d = wp_q + AW'(1);
            rr_d = (sel == SW'(num_src-1)) ? '0 : sel + SW'(1);
          end
          if (pop) rp_d = rp_q + AW'(1);
          occ_d = occ_q + OW'(push) - OW'(pop);
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      hold_q  <= HW'(rst_hold-1);
      rr_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rr_q    <= rr_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      occ_q   <= occ_d;
    end
  end

  // Storage needs no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.src_fb[sel];
  end
endmodule

// File: tb/tb_targ_fb_sched.sv
// Bench for targ_fb_sched: vector table for reset/basic/flush, hand-written
// sequences for full, flush, re-flush, mid-stream reset and round-robin order.
module tb_targ_fb_sched;
  localparam int NS = 4, FD = 8, RH = 2;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, stall = 1'b0;
  logic [$clog2(FD+1)-1:0] occupancy;
  logic busy;

  targ_fb_sched_if #(.num_src(NS)) bus();

  targ_fb_sched #(.num_src(NS), .fifo_depth(FD), .rst_hold(RH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .bus(bus), .occupancy(occupancy), .busy(busy));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [NS-1:0] vm = '0;
  logic [NS-1:0] xfer = '0;
  int cnt [NS];
  core::targ_pred_fb_t sb [$];
  int acc_log [$];

  typedef struct {
    logic r, f, s;
    logic [NS-1:0] vm, rdy;
    logic pv, en, prst;
    int occ;
    logic bz;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic core::targ_pred_fb_t make_rec(input int i, input int c);
    core::targ_pred_fb_t r;
    r.valid   = 1'b0;
    r.base_pc = {8'(i+1), 24'h0} + 32'(c*4);
    r.target  = r.base_pc ^ 32'h00ff_0000;
    r.taken   = c[0];
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      bus.src_fb[i]       = make_rec(i, cnt[i]);
      bus.src_fb[i].valid = vm[i];
    end
  endtask

  // Observe the cycle at the falling edge: log accepts, check drains.
  task automatic sample();
    core::targ_pred_fb_t e;
    @(negedge clk);
    xfer = '0;
    if (!rst_n) sb.delete();
    else begin
      for (int i = 0; i < NS; i++)
        if (bus.src_fb[i].valid && bus.src_ready[i]) begin
          xfer[i] = 1'b1;
          sb.push_back(bus.src_fb[i]);
          acc_log.push_back(i);
        end
      if (bus.pred_fb.valid && !stall) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL drain_unexpected: got pc %0h expected nothing", bus.pred_fb.base_pc);
        end else begin
          e = sb.pop_front();
          chk("drain_pc", 64'(bus.pred_fb.base_pc), 64'(e.base_pc));
          chk("drain_tgt", 64'({bus.pred_fb.target, bus.pred_fb.taken}), 64'({e.target, e.taken}));
        end
      end
      if (flush) sb.delete();
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) if (xfer[i]) cnt[i]++;
    drive();
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pat [3];
    pat[0] = 0; pat[1] = 1; pat[2] = 3;
    //              r     f     s     vm       rdy      pv    en    prst  occ bz
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0, 0, 1'b0};

    for (int i = 0; i < NS; i++) cnt[i] = 0;
    drive();
    @(posedge clk); #1;
    repeat (2) cyc();

    for (int r = 0; r < 12; r++) begin
      rst_n = tbl[r].r; flush = tbl[r].f; stall = tbl[r].s; vm = tbl[r].vm;
      drive();
      sample();
      chk($sformatf("v%0d.ready", r), 64'(bus.src_ready), 64'(tbl[r].rdy));
      chk($sformatf("v%0d.pvalid", r), 64'(bus.pred_fb.valid), 64'(tbl[r].pv));
      chk($sformatf("v%0d.pred_en", r), 64'(bus.pred_en), 64'(tbl[r].en));
      chk($sformatf("v%0d.pred_rst", r), 64'(bus.pred_rst), 64'(tbl[r].prst));
      chk($sformatf("v%0d.occ", r), 64'(occupancy), 64'(tbl[r].occ));
      chk($sformatf("v%0d.busy", r), 64'(busy), 64'(tbl[r].bz));
      adv();
    end
    flush = 1'b0; stall = 1'b0; vm = '0; drive();
    repeat (2) cyc();

    // Fill to full under stall, then drain.
    stall = 1'b1; vm = 4'b0001; drive();
    for (int c = 0; c < FD; c++) begin
      sample();
      chk("fill.ready", 64'(bus.src_ready), 64'(4'b0001));
      chk("fill.occ", 64'(occupancy), 64'(c));
      adv();
    end
    sample();
    chk("full.occ", 64'(occupancy), 64'(FD));
    chk("full.ready", 64'(bus.src_ready), 64'(0));
    chk("full.busy", 64'(busy), 64'(1));
    adv();
    stall = 1'b0; drive();
    sample();
    chk("full_pop.ready", 64'(bus.src_ready), 64'(0));
    chk("full_pop.pv", 64'(bus.pred_fb.valid), 64'(1));
    chk("full_pop.en", 64'(bus.pred_en), 64'(1));
    adv();
    sample();
    chk("resume.occ", 64'(occupancy), 64'(FD-1));
    chk("resume.ready", 64'(bus.src_ready), 64'(4'b0001));
    adv();
    vm = '0; drive();
    for (int c = 0; c < FD-1; c++) begin
      sample();
      chk("drain.pv", 64'(bus.pred_fb.valid), 64'(1));
      chk("drain.en", 64'(bus.pred_en), 64'(1));
      adv();
    end
    sample();
    chk("drained.pv", 64'(bus.pred_fb.valid), 64'(0));
    chk("drained.occ", 64'(occupancy), 64'(0));
    adv();

    // Flush with 5 buffered records.
    stall = 1'b1; vm = 4'b0001; drive();
    repeat (5) cyc();
    flush = 1'b1; stall = 1'b0; drive();
    sample();
    chk("flush.ready", 64'(bus.src_ready), 64'(0));
    chk("flush.pv", 64'(bus.pred_fb.valid), 64'(0));
    chk("flush.occ", 64'(occupancy), 64'(5));
    adv();
    flush = 1'b0; vm = '0; drive();
    sample();
    chk("fclr0.occ", 64'(occupancy), 64'(0));
    chk("fclr0.prst", 64'(bus.pred_rst), 64'(1));
    adv();
    sample();
    chk("fclr1.prst", 64'(bus.pred_rst), 64'(1));
    adv();
    sample();
    chk("frun.prst", 64'(bus.pred_rst), 64'(0));
    chk("frun.busy", 64'(busy), 64'(0));
    chk("frun.pv", 64'(bus.pred_fb.valid), 64'(0));
    adv();
    vm = 4'b0001; drive();
    cyc();
    vm = '0; drive();
    repeat (2) cyc();

    // Flush re-asserted inside the clear window.
    flush = 1'b1; drive();
    cyc();
    flush = 1'b0;
    sample(); chk("reflush.a", 64'(bus.pred_rst), 64'(1)); adv();
    flush = 1'b1;
    sample(); chk("reflush.b", 64'(bus.pred_rst), 64'(1)); adv();
    flush = 1'b0;
    sample(); chk("reflush.c", 64'(bus.pred_rst), 64'(1)); adv();
    sample(); chk("reflush.d", 64'(bus.pred_rst), 64'(1)); adv();
    sample(); chk("reflush.run", 64'(bus.pred_rst), 64'(0)); adv();

    // Reset mid-stream with 3 buffered records, then round-robin order.
    stall = 1'b1; vm = 4'b0001; drive();
    repeat (3) cyc();
    rst_n = 1'b0; stall = 1'b0; vm = '0; drive();
    sample();
    chk("prerst.occ", 64'(occupancy), 64'(3));
    adv();
    rst_n = 1'b1; vm = 4'b1011; drive();
    sample();
    chk("rst.occ", 64'(occupancy), 64'(0));
    chk("rst.pv", 64'(bus.pred_fb.valid), 64'(0));
    chk("rst.prst", 64'(bus.pred_rst), 64'(1));
    chk("rst.ready", 64'(bus.src_ready), 64'(0));
    adv();
    sample();
    chk("rst1.prst", 64'(bus.pred_rst), 64'(1));
    adv();
    acc_log.delete();
    for (int c = 0; c < 12; c++) begin
      sample();
      if (c == 0) chk("rr.first", 64'(bus.src_ready), 64'(4'b0001));
      else begin
        chk("rr.pv", 64'(bus.pred_fb.valid), 64'(1));
        chk("rr.occ", 64'(occupancy), 64'(1));
      end
      adv();
    end
    chk("rr.count", 64'(acc_log.size()), 64'(12));
    for (int k = 0; k < 12 && k < acc_log.size(); k++)
      chk($sformatf("rr.order%0d", k), 64'(acc_log[k]), 64'(pat[k%3]));
    vm = '0; drive();
    repeat (2) cyc();
    chk("end.occ", 64'(occupancy), 64'(0));
    chk("end.sb", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
